// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared definitions for the data-memory responder: access-size
//            encodings, FSM state type and a size-to-byte-count helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 4'd1;
      SZ_H:    size_bytes = 4'd2;
      SZ_W:    size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Purpose  : Request/response handshake bundle between the core's data port
//            (master) and the memory responder (slave).
// Signals  : req_valid/req_ready/req_write/req_addr/req_wdata/req_size/
//            req_unsigned (request), rsp_valid/rsp_ready/rsp_rdata/rsp_error
//            (response).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface : dmem_responder_if
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_load_align
// Purpose  : Combinational load formatter. Takes the eight bytes starting at
//            the access address (byte 0 in raw[7:0]) and returns the selected
//            size, sign- or zero-extended to 64 bits.
// Ports    : raw[63:0]   little-endian bytes from the array
//            size[1:0]   access size encoding
//            is_unsigned 1 = zero-extend, 0 = sign-extend
//            rdata[63:0] extended load result
// Revision : 1.0 - initial release
// ============================================================================
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [63:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] rdata
);

  always_comb begin
    rdata = raw;
    case (size)
      SZ_B:    rdata = {{56{~is_unsigned & raw[7]}},  raw[7:0]};
      SZ_H:    rdata = {{48{~is_unsigned & raw[15]}}, raw[15:0]};
      SZ_W:    rdata = {{32{~is_unsigned & raw[31]}}, raw[31:0]};
      default: rdata = raw;
    endcase
  end

endmodule : dmem_load_align
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-outstanding data-memory responder with a fixed access
//            latency and little-endian byte/half/word/double accesses into an
//            internal byte array. Out-of-range accesses return rsp_error.
// Ports    : clk    rising-edge clock
//            reset  asynchronous active-low reset
//            bus    dmem_responder_if.slave (request + response handshakes)
// Options  : DMEM_MISALIGN_TRAP_EN - when defined, misaligned accesses fault.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int          AW    = $clog2(DEPTH_BYTES);
  localparam logic [63:0] DEPTH = 64'(DEPTH_BYTES);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [63:0] rdata_q;
  logic        error_q;

  logic [7:0]  mem [0:DEPTH_BYTES-1];

  logic        accept;
  logic        access;
  logic [3:0]  nbytes;
  logic        range_err;
  logic        misalign;
  logic        err;
  logic [63:0] raw;
  logic [63:0] load_data;
  logic [AW:0] idx [8];

  assign accept = (state == IDLE) & bus.req_valid;
  assign access = (state == WAIT) & (cnt == 4'd0);
  assign nbytes = size_bytes(lat_size);

  // The first term also catches huge addresses where addr+size would wrap.
  assign range_err = (lat_addr >= DEPTH) | ((lat_addr + {60'd0, nbytes}) > DEPTH);

`ifdef DMEM_MISALIGN_TRAP_EN
  // nbytes-1 is the alignment mask (0,1,3,7); the double case wraps 8 -> 0 -> 7.
  assign misalign = |(lat_addr[2:0] & (nbytes[2:0] - 3'd1));
`else
  assign misalign = 1'b0;
`endif

  assign err = range_err | misalign;

  // Byte lanes beyond the array end read as zero; they are only ever
  // consulted for accesses that already fault.
  for (genvar i = 0; i < 8; i++) begin : g_byte
    assign idx[i] = {1'b0, lat_addr[AW-1:0]} + (AW+1)'(i);
    assign raw[8*i +: 8] = (idx[i] < (AW+1)'(DEPTH_BYTES)) ? mem[idx[i][AW-1:0]] : 8'h00;
  end

  dmem_load_align u_align (
    .raw         (raw),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .rdata       (load_data)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; the access edge is the WAIT cycle with cnt==0, so
  // rsp_valid appears LATENCY+1 edges after the accept edge.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid)  state_nx = WAIT;
      WAIT:    if (cnt == 4'd0)    state_nx = RESP;
      RESP:    if (bus.rsp_ready)  state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE:    bus.req_ready = 1'b1;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;

  // Request latch, latency counter and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= 4'd0;
      lat_write    <= 1'b0;
      lat_addr     <= 64'd0;
      lat_wdata    <= 64'd0;
      lat_size     <= SZ_B;
      lat_unsigned <= 1'b0;
      rdata_q      <= 64'd0;
      error_q      <= 1'b0;
    end else begin
      if (accept) begin
        lat_write    <= bus.req_write;
        lat_addr     <= bus.req_addr;
        lat_wdata    <= bus.req_wdata;
        lat_size     <= bus.req_size;
        lat_unsigned <= bus.req_unsigned;
        cnt          <= LAT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        rdata_q <= (lat_write | err) ? 64'd0 : load_data;
        error_q <= err;
      end else if ((state == RESP) && bus.rsp_ready) begin
        rdata_q <= 64'd0;
        error_q <= 1'b0;
      end
    end
  end

  // Byte array: never reset. A store commits all its bytes at the access edge.
  always_ff @(posedge clk) begin
    if (access && lat_write && !err) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nbytes) mem[idx[i][AW-1:0]] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. A byte-array model
//            predicts every response; a negedge monitor compares the DUT
//            outputs to it on each cycle, and directed cases pin the model
//            with literal values. Honours DMEM_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 512;
  localparam int LAT   = 2;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  int   ncyc    = 0;
  int   acc_n   = 0;
  bit   prev_valid = 1'b0;
  exp_t exp_q[$];
  logic [7:0] model_mem [DEPTH];

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: event did not occur within the cycle budget", name);
  endtask

  // Reference model: applies the access rules to the byte array directly.
  function automatic exp_t model_access(input bit w, input logic [63:0] a,
                                        input logic [63:0] d, input logic [1:0] s,
                                        input bit u);
    exp_t e;
    int   n;
    logic [63:0] v;
    n = 1 << s;
    e.rdata = 64'd0;
    e.err = (a >= 64'(DEPTH)) || ((a + 64'(n)) > 64'(DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((a % 64'(n)) != 0) e.err = 1'b1;
`endif
    if (e.err) return e;
    if (w) begin
      for (int i = 0; i < n; i++) model_mem[int'(a) + i] = d[8*i +: 8];
    end else begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[int'(a) + i];
      if (!u && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
      e.rdata = v;
    end
    return e;
  endfunction

  // Monitor: outputs are checked every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          check("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
          check("rsp_error", {63'd0, bus.rsp_error}, {63'd0, exp_q[0].err});
        end
        check("req_ready_in_resp", {63'd0, bus.req_ready}, 64'd0);
        if (!prev_valid) check("latency", 64'(ncyc - acc_n), 64'(LAT + 1));
      end else begin
        check("idle_rdata", bus.rsp_rdata, 64'd0);
        check("idle_error", {63'd0, bus.rsp_error}, 64'd0);
      end
      prev_valid = bus.rsp_valid;
    end
  end

  // One complete request/response transaction; returns the DUT's response.
  task automatic xact(input bit w, input logic [63:0] a, input logic [63:0] d,
                      input logic [1:0] s, input bit u, input int hold,
                      output logic [63:0] rd, output logic er);
    int t;
    rd = 64'd0;
    er = 1'b0;
    @(negedge clk);
    bus.req_write    = w;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    bus.req_size     = s;
    bus.req_unsigned = u;
    bus.req_valid    = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin fail_now("req_ready"); bus.req_valid = 1'b0; return; end
    exp_q.push_back(model_access(w, a, d, s, u));
    acc_n = ncyc + 1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    t = 0;
    while (!bus.rsp_valid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin fail_now("rsp_valid"); void'(exp_q.pop_front()); return; end
    repeat (hold) @(negedge clk);
    rd = bus.rsp_rdata;
    er = bus.rsp_error;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    void'(exp_q.pop_front());
  endtask

  initial begin
    logic [63:0] rd, old, old2;
    logic        er;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 64'd0;
    bus.req_wdata = 64'd0; bus.req_size = SZ_B; bus.req_unsigned = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;

    #12;
    check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    check("rst_rsp_error", {63'd0, bus.rsp_error}, 64'd0);
    @(negedge clk) reset = 1'b1;

    // Fill the array with known random content.
    for (int a = 0; a < DEPTH; a += 8)
      xact(1'b1, 64'(a), {$urandom, $urandom}, SZ_D, 1'b0, 0, rd, er);

    // Double store/load round trip.
    xact(1'b1, 64'h10, 64'h1122334455667788, SZ_D, 1'b0, 0, rd, er);
    check("st_d_rdata", rd, 64'd0);
    xact(1'b0, 64'h10, 64'd0, SZ_D, 1'b0, 0, rd, er);
    check("ld_d_rdata", rd, 64'h1122334455667788);
    check("ld_d_error", {63'd0, er}, 64'd0);

    // Byte store with sign/zero extension; neighbours untouched.
    xact(1'b0, 64'h20, 64'd0, SZ_D, 1'b0, 0, old, er);
    xact(1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FF80, SZ_B, 1'b0, 0, rd, er);
    xact(1'b0, 64'h20, 64'd0, SZ_B, 1'b0, 0, rd, er);
    check("ld_b_signed", rd, 64'hFFFFFFFFFFFFFF80);
    xact(1'b0, 64'h20, 64'd0, SZ_B, 1'b1, 0, rd, er);
    check("ld_b_unsigned", rd, 64'h0000000000000080);
    xact(1'b0, 64'h20, 64'd0, SZ_D, 1'b0, 0, rd, er);
    check("ld_d_after_b", rd, {old[63:8], 8'h80});

    // Range faults at the top of the array.
    xact(1'b0, 64'd510, 64'd0, SZ_W, 1'b0, 0, rd, er);
    check("oor_ld_error", {63'd0, er}, 64'd1);
    check("oor_ld_rdata", rd, 64'd0);
    xact(1'b0, 64'd508, 64'd0, SZ_W, 1'b1, 0, old, er);
    xact(1'b1, 64'd508, 64'hDEADBEEFCAFEF00D, SZ_D, 1'b0, 0, rd, er);
    check("oor_st_error", {63'd0, er}, 64'd1);
    xact(1'b0, 64'd508, 64'd0, SZ_W, 1'b1, 0, rd, er);
    check("oor_st_nowrite", rd, old);
    xact(1'b0, 64'h8000_0000_0000_0010, 64'd0, SZ_B, 1'b0, 0, rd, er);
    check("oor_high_error", {63'd0, er}, 64'd1);

    // Backpressure: response held for five cycles.
    xact(1'b0, 64'h10, 64'd0, SZ_W, 1'b0, 5, rd, er);
    check("hold_rdata", rd, 64'h0000000055667788);
    @(negedge clk);
    check("ready_after_rsp", {63'd0, bus.req_ready}, 64'd1);

    // Reset in the middle of a store's WAIT phase drops the store.
    xact(1'b0, 64'h30, 64'd0, SZ_D, 1'b0, 0, old, er);
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_addr = 64'h30; bus.req_wdata = ~old;
    bus.req_size = SZ_D; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("midrst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("midrst_rsp_rdata", bus.rsp_rdata, 64'd0);
    check("midrst_rsp_error", {63'd0, bus.rsp_error}, 64'd0);
    @(negedge clk) reset = 1'b1;
    xact(1'b0, 64'h30, 64'd0, SZ_D, 1'b0, 0, rd, er);
    check("midrst_store_dropped", rd, old);

`ifdef DMEM_MISALIGN_TRAP_EN
    xact(1'b0, 64'h41, 64'd0, SZ_H, 1'b1, 0, rd, er);
    check("misalign_error", {63'd0, er}, 64'd1);
    check("misalign_rdata", rd, 64'd0);
`else
    xact(1'b1, 64'h41, 64'hBEEF, SZ_H, 1'b0, 0, rd, er);
    xact(1'b0, 64'h41, 64'd0, SZ_H, 1'b1, 0, rd, er);
    check("misalign_ld_u", rd, 64'h000000000000BEEF);
    check("misalign_ld_err", {63'd0, er}, 64'd0);
    xact(1'b0, 64'h41, 64'd0, SZ_H, 1'b0, 0, rd, er);
    check("misalign_ld_s", rd, 64'hFFFFFFFFFFFFBEEF);
`endif

    // Randomised traffic; the monitor compares each response to the model.
    for (int k = 0; k < 300; k++) begin
      logic [63:0] a;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      a = {$urandom, $urandom};
      else if (r == 1) a = 64'(DEPTH - int'($urandom_range(0, 8)));
      else             a = 64'($urandom_range(0, DEPTH - 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xact(1'($urandom), a, {$urandom, $urandom}, 2'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)), rd, er);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire
